// File: rtl/add32_pipe.sv
`timescale 1ns/1ps
// add32_pipe: two-stage pipelined 32-bit adder/subtractor with valid/ready on both sides.
// Stage 1 resolves the low half through 4-bit group lookahead; stage 2 finishes the high half and flags.
module add32_pipe (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        sub,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] sum,
   output logic        cout,
   output logic        ovf,
   output logic        zero
);

   logic [31:0] bx;
   logic [15:0] p_lo, g_lo, bit_c, sum_lo_d;
   logic [3:0]  grp_g, grp_p;
   logic [3:0]  grp_c;
   logic        c16_d;

   logic        s1_valid_q, s1_valid_d;
   logic [15:0] sum_lo_q, a_hi_q, bx_hi_q;
   logic        c16_q;

   logic        s2_valid_q, s2_valid_d;
   logic [31:0] sum_q, sum_d;
   logic        cout_q, ovf_q, zero_q;
   logic [15:0] sum_hi_d;
   logic        c31_d, c32_d;

   logic        s1_load, s2_load;

   assign bx   = sub ? ~b : b;
   assign p_lo = a[15:0] ^ bx[15:0];
   assign g_lo = a[15:0] & bx[15:0];

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_group
         assign grp_g[gi] = g_lo[4*gi+3]
                          | (p_lo[4*gi+3] & g_lo[4*gi+2])
                          | (p_lo[4*gi+3] & p_lo[4*gi+2] & g_lo[4*gi+1])
                          | (p_lo[4*gi+3] & p_lo[4*gi+2] & p_lo[4*gi+1] & g_lo[4*gi]);
         assign grp_p[gi] = &p_lo[4*gi+3:4*gi];
      end
   endgenerate

   // Flattened lookahead: every group carry depends only on group G/P and the carry-in.
   always_comb begin
      grp_c[0] = sub;
      grp_c[1] = grp_g[0] | (grp_p[0] & sub);
      grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & sub);
      grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
               | (grp_p[2] & grp_p[1] & grp_p[0] & sub);
      c16_d    = grp_g[3] | (grp_p[3] & grp_c[3]);
   end

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_bit
         if (gi % 4 == 0) begin : g_head
            assign bit_c[gi] = grp_c[gi/4];
         end else begin : g_ripple
            assign bit_c[gi] = g_lo[gi-1] | (p_lo[gi-1] & bit_c[gi-1]);
         end
         assign sum_lo_d[gi] = p_lo[gi] ^ bit_c[gi];
      end
   endgenerate

   // Carry into bit 31 recovered from the sum bit: s31 = a31 ^ bx31 ^ c31.
   always_comb begin
      {c32_d, sum_hi_d} = {1'b0, a_hi_q} + {1'b0, bx_hi_q} + {16'd0, c16_q};
      c31_d             = a_hi_q[15] ^ bx_hi_q[15] ^ sum_hi_d[15];
      sum_d             = {sum_hi_d, sum_lo_q};
   end

   assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
   assign s1_load  = in_valid && in_ready;
   assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);

   always_comb begin
      s1_valid_d = s1_valid_q;
      if (s1_load)
         s1_valid_d = 1'b1;
      else if (s2_load)
         s1_valid_d = 1'b0;

      s2_valid_d = s2_valid_q;
      if (s2_load)
         s2_valid_d = 1'b1;
      else if (out_ready)
         s2_valid_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         sum_lo_q   <= '0;
         c16_q      <= 1'b0;
         a_hi_q     <= '0;
         bx_hi_q    <= '0;
         s2_valid_q <= 1'b0;
         sum_q      <= '0;
         cout_q     <= 1'b0;
         ovf_q      <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         if (s1_load) begin
            sum_lo_q <= sum_lo_d;
            c16_q    <= c16_d;
            a_hi_q   <= a[31:16];
            bx_hi_q  <= bx[31:16];
         end
         if (s2_load) begin
            sum_q  <= sum_d;
            cout_q <= c32_d;
            ovf_q  <= c31_d ^ c32_d;
            zero_q <= ~|sum_d;
         end
      end
   end

   assign out_valid = s2_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule
